// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: SPI slave transaction sequencer driving address-latch, shift-load, memory-write strobes and MISO enable
// Defining SPI_XFER_STATUS_EN adds the busy and abort status outputs.
module spi_xfer_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic cs,
  input  logic sclk_rise,
  input  logic sclk_fall,
  input  logic rw_bit,
`ifdef SPI_XFER_STATUS_EN
  output logic busy,
  output logic abort,
`endif
  output logic addr_we,
  output logic sr_we,
  output logic dm_we,
  output logic miso_en
);
  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT, WRITE_RECV, WRITE_COMMIT, DONE
  } state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic tick, last;
  assign tick = (state == READ_SHIFT) ? sclk_fall : (state == GET_ADDR || state == WRITE_RECV) && sclk_rise;
  assign last = tick && cnt == LAST;
  // Next state; a deselect overrides everything, including a coincident counting edge
  always_comb begin
    nxt = state;
    case (state)
      IDLE:         nxt = GET_ADDR;
      GET_ADDR:     nxt = last ? GOT_ADDR : GET_ADDR;
      GOT_ADDR:     nxt = rw_bit ? READ_LOAD : WRITE_RECV;
      READ_LOAD:    nxt = READ_SHIFT;
      READ_SHIFT:   nxt = last ? DONE : READ_SHIFT;
      WRITE_RECV:   nxt = last ? WRITE_COMMIT : WRITE_RECV;
      WRITE_COMMIT: nxt = DONE;
      default:      nxt = DONE;
    endcase
    if (cs) nxt = IDLE;
  end
  // State, saturating bit counter (cleared on every state change) and outputs registered from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_we <= 1'b0;
      sr_we   <= 1'b0;
      dm_we   <= 1'b0;
      miso_en <= 1'b0;
`ifdef SPI_XFER_STATUS_EN
      busy    <= 1'b0;
      abort   <= 1'b0;
`endif
    end else begin
      state   <= nxt;
      cnt     <= (nxt != state) ? '0 : (tick && cnt != FULL) ? cnt + 1'b1 : cnt;
      addr_we <= nxt == GOT_ADDR;
      sr_we   <= nxt == READ_LOAD;
      dm_we   <= nxt == WRITE_COMMIT;
      miso_en <= nxt == READ_SHIFT;
`ifdef SPI_XFER_STATUS_EN
      busy    <= nxt != IDLE && nxt != DONE;
      abort   <= cs && state != IDLE && state != DONE;
`endif
    end
  end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: scoreboard bench for spi_xfer_ctrl; strobe/enable events are matched against expected (event, cycle) pairs
module tb_spi_xfer_ctrl;
  localparam int EV_ADDR = 0, EV_SR = 1, EV_DM = 2, EV_MRISE = 3, EV_MFALL = 4, EV_ABORT = 5;
  typedef struct {int code; int cyc;} ev_t;
  logic clk = 0, reset = 1, cs = 1, sclk_rise = 0, sclk_fall = 0, rw_bit, mosi = 0;
  logic addr_we, sr_we, dm_we, miso_en;
`ifdef SPI_XFER_STATUS_EN
  logic busy, abort;
`endif
  logic [7:0] sr = 8'h00;
  logic mon_on = 0, prev_miso = 0;
  int cyc = 0, n_chk = 0, n_fail = 0;
  ev_t exp_q[$];

  spi_xfer_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .rw_bit(rw_bit),
`ifdef SPI_XFER_STATUS_EN
    .busy(busy), .abort(abort),
`endif
    .addr_we(addr_we), .sr_we(sr_we), .dm_we(dm_we), .miso_en(miso_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (sclk_rise) sr <= {sr[6:0], mosi};
  assign rw_bit = sr[0];

  function automatic string ev_name(input int code);
    case (code)
      EV_ADDR:  return "addr_we";
      EV_SR:    return "sr_we";
      EV_DM:    return "dm_we";
      EV_MRISE: return "miso_en_rise";
      EV_MFALL: return "miso_en_fall";
      default:  return "abort";
    endcase
  endfunction

  task automatic check_ev(input int code);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL event: got %s at cycle %0d, required no event", ev_name(code), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.code != code || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL event: got %s at cycle %0d, required %s at cycle %0d", ev_name(code), cyc, ev_name(e.code), e.cyc);
      end
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  always @(negedge clk) if (mon_on) begin
    if (addr_we === 1'b1) check_ev(EV_ADDR);
    if (sr_we === 1'b1) check_ev(EV_SR);
    if (dm_we === 1'b1) check_ev(EV_DM);
    if (miso_en === 1'b1 && prev_miso !== 1'b1) check_ev(EV_MRISE);
    if (miso_en !== 1'b1 && prev_miso === 1'b1) check_ev(EV_MFALL);
`ifdef SPI_XFER_STATUS_EN
    if (abort === 1'b1) check_ev(EV_ABORT);
`endif
    prev_miso = miso_en;
  end

  task automatic step(input logic c, input logic r, input logic f);
    cs = c;
    sclk_rise = r;
    sclk_fall = f;
    @(posedge clk);
    #1;
    sclk_rise = 0;
    sclk_fall = 0;
  endtask

  task automatic expect_ev(input int code);
    exp_q.push_back('{code, cyc});
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      step(0, 0, 1);
      mosi = b[i];
      step(0, 1, 0);
    end
  endtask

  task automatic expect_abort();
`ifdef SPI_XFER_STATUS_EN
    expect_ev(EV_ABORT);
`endif
  endtask

  task automatic write_xfer(input logic [7:0] a, input logic [7:0] d);
    step(0, 0, 0);
    send_byte(a);
    expect_ev(EV_ADDR);
    send_byte(d);
    expect_ev(EV_DM);
  endtask

  task automatic read_head(input logic [7:0] a);
    step(0, 0, 0);
    send_byte(a);
    expect_ev(EV_ADDR);
    step(0, 0, 0);
    expect_ev(EV_SR);
    step(0, 0, 0);
    expect_ev(EV_MRISE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    cs = 1;
    repeat (3) step(1, 1, 1);
    reset = 0;
    check_bit("reset_addr_we", addr_we, 1'b0);
    check_bit("reset_sr_we", sr_we, 1'b0);
    check_bit("reset_dm_we", dm_we, 1'b0);
    check_bit("reset_miso_en", miso_en, 1'b0);
`ifdef SPI_XFER_STATUS_EN
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_abort", abort, 1'b0);
`endif
    prev_miso = 0;
    mon_on = 1;
    step(1, 0, 0);
    // 1: write 0x2A / 0xA5
    write_xfer(8'h2A, 8'hA5);
    step(1, 0, 0);
    step(1, 0, 0);
    // 2: read 0x2B, miso_en spans 8 falls
    read_head(8'h2B);
`ifdef SPI_XFER_STATUS_EN
    check_bit("busy_read_shift", busy, 1'b1);
`endif
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0);
      step(0, 0, 1);
    end
    expect_ev(EV_MFALL);
    step(0, 1, 1);
    step(1, 0, 0);
    // 3: abort after 5 address rises; edges ignored while deselected
    step(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1);
      step(0, 1, 0);
    end
    step(1, 0, 0);
    expect_abort();
    repeat (4) step(1, 1, 0);
    // 4: deselect coincides with 8th data rise
    step(0, 0, 0);
    send_byte(8'h2A);
    expect_ev(EV_ADDR);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1);
      step(0, 1, 0);
    end
    step(0, 0, 1);
    step(1, 1, 0);
    expect_abort();
    repeat (3) step(1, 0, 0);
    // 5: reset during READ_SHIFT, then a full write
    read_head(8'h2B);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1);
      step(0, 1, 0);
    end
    reset = 1;
    step(0, 0, 1);
    expect_ev(EV_MFALL);
    reset = 0;
    check_bit("miso_after_reset", miso_en, 1'b0);
    write_xfer(8'h10, 8'h55);
    step(1, 0, 0);
    // 6: back-to-back writes with one deselected cycle; rises in DONE ignored
    write_xfer(8'h2A, 8'h11);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0);
      step(0, 0, 1);
    end
    step(1, 0, 0);
    write_xfer(8'h04, 8'hC3);
    step(1, 0, 0);
    repeat (5) step(1, 1, 1);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending: %0d required events never seen, first %s at cycle %0d", exp_q.size(), ev_name(exp_q[0].code), exp_q[0].cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
